fpu_arbiter: RTL and testbench
==============================

# fpu_arbiter

Shares one combinational `fpu` instance between two requesters, each using a valid/ready handshake. Grants are round-robin. The block registers the operands of the granted request, drives the FPU for one execute cycle, and registers the result. It then returns the result, tagged with the requester id, on a single response channel. It sits between the `fpu` datapath and its clients. Requests with op `2'b11` (divide) are not executed; they complete immediately with an error response.

## Interface

Parameters:
- `CNT_W`, 16, width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request pending from requester 0 / 1.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high together with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  IEEE-754 single operands.
- `req0_op` / `req1_op`  in  2  operation: 00 add, 01 sub, 10 mul, 11 div (unsupported).
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accepts.
- `rsp_id`  out  1  requester the response belongs to.
- `rsp_result`  out  32  result bits.
- `rsp_err`  out  1  1 = unsupported op; result is qNaN.
- `fpu_a`, `fpu_b`  out  32  operands to the `fpu` instance.
- `fpu_s`  out  2  select to the `fpu` instance.
- `fpu_out`  in  32  `fpu` result.
- `busy`  out  1  state != IDLE.
- `op_count`  out  CNT_W  completed responses, wrapping.

## Operation

- The block is single-outstanding and uses three states: IDLE, EXEC, RESP.
- **Grant, combinational, IDLE only:**
  - If exactly one request is valid, grant it.
  - If both are valid, grant the id != `last_id`.
  - `reqN_ready = (state==IDLE) && grant==N`. Both ready lines are 0 outside IDLE.
- **IDLE, on handshake:**
  - Capture a, b, op into the issue registers, which drive `fpu_a`/`fpu_b`/`fpu_s`.
  - Capture id into `rsp_id`.
  - Set `last_id` = id.
  - If op==11: load `rsp_result`=32'h7FC00000, `rsp_err`=1, go to RESP. The FPU is not used.
  - Otherwise set `rsp_err`=0 and go to EXEC.
- **EXEC:** one cycle. At its end, capture `fpu_out` into `rsp_result` and go to RESP.
- **RESP:**
  - `rsp_valid`=1; result, id and err are held stable.
  - On `rsp_ready`: go to IDLE, `rsp_valid`→0, `op_count`+1, wrapping from all-ones to 0.
- **Issue registers:** hold their value outside the capture cycle, so the FPU inputs are stable from EXEC through RESP.
- **Requester rule:** a requester holds a, b, op stable while valid && !ready. The arbiter does not require valid to stay asserted.
- **Reset values:**
  - state IDLE, `last_id`=1 (req0 wins the first tie).
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_err`=0.
  - `fpu_a`=`fpu_b`=0, `fpu_s`=00, `op_count`=0, `busy`=0.
- **Reset mid-operation** (EXEC or RESP): the operation is abandoned without a response or count increment, and all outputs take their reset values on the next edge.

## Timing

- Request handshake in cycle N (valid && ready sampled at edge N+1).
- Add/sub/mul: EXEC in cycle N+1; `rsp_valid` first high in cycle N+2.
- Div (err): `rsp_valid` first high in cycle N+1.
- If the response handshake happens in cycle M, the next request can be accepted in cycle M+1 at the earliest. Back-to-back throughput with `rsp_ready` held high is 1 op per 3 cycles (add/sub/mul) or 2 cycles (div).
- **Simultaneous events:**
  - A request arriving while in RESP with `rsp_ready` high is not accepted until the next cycle (IDLE).
  - If both valid lines rise in the same cycle, only one is granted; the other waits, with its ready=0.
- **Backpressure:** `rsp_ready`=0 holds RESP indefinitely, and both ready lines stay 0.
- **Fairness:** under continuous contention, grants alternate 0,1,0,1…

## Test plan

- **Single add:** req0 a=3FC00000, b=40100000, op=00, `rsp_ready`=1 → `req0_ready` high in cycle 0; `rsp_valid` in cycle 2 with result 40700000, id 0, err 0; `op_count`=1.
- **Sub and mul from req1:** sub gives BF400000; mul gives 40580000. Each response has id 1, latency 2, and `fpu_s` equals the op during EXEC.
- **Contention:** both requesters valid continuously, starting after reset → grant order 0,1,0,1; responses carry matching ids; neither ready is high while `busy`.
- **Divide:** req0 op=11 → `rsp_valid` in cycle 1, result 7FC00000, err 1; `fpu_s` becomes 11 and `fpu_a`/`fpu_b` take the div request's operands, but `rsp_result` is the fixed qNaN, not `fpu_out`.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → result, id and err stay stable, reqs are stalled; accepted on the cycle `rsp_ready` rises, with IDLE next.
- **Reset mid-EXEC, and counter wrap:**
  - Reset asserted in EXEC → next cycle all outputs are at reset values and no response appears.
  - With `CNT_W`=2, four completions → `op_count` goes 1,2,3,0.

Source files
------------

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one combinational FPU between two valid/ready requesters.
// Round-robin grant in IDLE, one EXEC cycle through the FPU, then the result is
// held on a single response channel (tagged with requester id) until accepted.
// Divide requests bypass the FPU and complete at once with an error response.
module fpu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_err,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_s,
  input  logic [31:0]      fpu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic [1:0]  OP_DIV = 2'b11;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_id;
  logic               w_grant_vld;
  logic               w_grant_id;
  logic               w_rsp_hs;
  logic [31:0]        w_a_sel;
  logic [31:0]        w_b_sel;
  logic [1:0]         w_op_sel;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [1:0]         r_fpu_s;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [31:0]        r_rsp_result;
  logic               r_rsp_err;
  logic               r_busy;
  logic [CNT_W-1:0]   r_op_count;

  // Round-robin grant, only offered while IDLE; on a tie the id that did not win last time goes.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ~r_last_id;
      end else if (req0_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b0;
      end else if (req1_valid) begin
        w_grant_vld = 1'b1;
        w_grant_id  = 1'b1;
      end else begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
      end
    end else begin
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
    end
  end

  // Operand mux selecting the granted requester's payload for capture.
  always_comb begin
    w_a_sel  = req0_a;
    w_b_sel  = req0_b;
    w_op_sel = req0_op;
    if (w_grant_id) begin
      w_a_sel  = req1_a;
      w_b_sel  = req1_b;
      w_op_sel = req1_op;
    end else begin
      w_a_sel  = req0_a;
      w_b_sel  = req0_b;
      w_op_sel = req0_op;
    end
  end

  assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready;

  // Next-state logic: IDLE -> EXEC (or straight to RESP for divide) -> RESP -> IDLE on accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = (w_op_sel == OP_DIV) ? ST_RESP : ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Issue registers and arbitration history: loaded only on a request handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fpu_a   <= 32'h0000_0000;
      r_fpu_b   <= 32'h0000_0000;
      r_fpu_s   <= 2'b00;
      r_last_id <= 1'b1;
      r_rsp_id  <= 1'b0;
    end else if (w_grant_vld) begin
      r_fpu_a   <= w_a_sel;
      r_fpu_b   <= w_b_sel;
      r_fpu_s   <= w_op_sel;
      r_last_id <= w_grant_id;
      r_rsp_id  <= w_grant_id;
    end else begin
      r_fpu_a   <= r_fpu_a;
      r_fpu_b   <= r_fpu_b;
      r_fpu_s   <= r_fpu_s;
      r_last_id <= r_last_id;
      r_rsp_id  <= r_rsp_id;
    end
  end

  // Response payload: fixed qNaN for divide at handshake, FPU output at the end of EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_result <= 32'h0000_0000;
      r_rsp_err    <= 1'b0;
    end else if (w_grant_vld) begin
      if (w_op_sel == OP_DIV) begin
        r_rsp_result <= QNAN;
        r_rsp_err    <= 1'b1;
      end else begin
        r_rsp_result <= r_rsp_result;
        r_rsp_err    <= 1'b0;
      end
    end else if (r_state == ST_EXEC) begin
      r_rsp_result <= fpu_out;
      r_rsp_err    <= r_rsp_err;
    end else begin
      r_rsp_result <= r_rsp_result;
      r_rsp_err    <= r_rsp_err;
    end
  end

  // Completed-response counter, wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_rsp_hs) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end else begin
      r_op_count <= r_op_count;
    end
  end

  assign req0_ready = w_grant_vld && !w_grant_id;
  assign req1_ready = w_grant_vld &&  w_grant_id;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;
  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_s      = r_fpu_s;
  assign busy       = r_busy;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Testbench for fpu_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_fpu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0]      rsp_result;
  logic [31:0]      fpu_a, fpu_b, fpu_out;
  logic [1:0]       fpu_s;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  fpu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_s(fpu_s), .fpu_out(fpu_out),
    .busy(busy), .op_count(op_count)
  );

  // Stand-in combinational FPU: exact IEEE results for the reference operand
  // pair, cheap integer mixes otherwise (distinct per op so selects are visible).
  function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s);
    if (a == 32'h3FC0_0000 && b == 32'h4010_0000) begin
      case (s)
        2'b00:   return 32'h4070_0000;
        2'b01:   return 32'hBF40_0000;
        2'b10:   return 32'h4058_0000;
        default: return 32'hDEAD_BEEF;
      endcase
    end
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return a ^ b ^ 32'h5555_AAAA;
    endcase
  endfunction

  assign fpu_out = fpu_fn(fpu_a, fpu_b, fpu_s);

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: one outstanding transaction and the cycle its response appears.
  bit               m_have;
  int               m_avail;
  logic             m_last;
  logic             m_id, m_err;
  logic [31:0]      m_res, m_a, m_b;
  logic [1:0]       m_op;
  logic [CNT_W-1:0] m_cnt;

  // Traffic generator state: a requester holds its payload until accepted.
  bit          pend0, pend1;
  logic [31:0] ga0, gb0, ga1, gb1;
  logic [1:0]  gop0, gop1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0; m_avail = 0; m_last = 1'b1;
    m_id = 1'b0; m_err = 1'b0; m_res = 32'h0; m_a = 32'h0; m_b = 32'h0;
    m_op = 2'b00; m_cnt = '0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model, take the edge.
  task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [1:0] op0,
                      input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] op1,
                      input logic rr, input logic rn,
                      output logic acc0, output logic acc1);
    logic idle, gv, gid, exp_rv;
    logic [31:0] sa, sb;
    logic [1:0] sop;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready = rr; rst_n = rn;
    @(negedge clk);
    idle = !m_have;
    gv   = idle && (v0 || v1);
    gid  = (v0 && v1) ? !m_last : (v1 && !v0);
    exp_rv = m_have && (cyc >= m_avail);
    check("req0_ready", req0_ready, gv && !gid);
    check("req1_ready", req1_ready, gv && gid);
    check("rsp_valid", rsp_valid, exp_rv);
    check("busy", busy, m_have);
    check("op_count", op_count, m_cnt);
    check("fpu_a", fpu_a, m_a);
    check("fpu_b", fpu_b, m_b);
    check("fpu_s", fpu_s, m_op);
    if (exp_rv) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_result", rsp_result, m_res);
      check("rsp_err", rsp_err, m_err);
    end
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rn) begin
      model_reset();
    end else if (exp_rv && rr) begin
      m_have = 1'b0;
      m_cnt  = m_cnt + 1'b1;
    end else if (gv) begin
      sa  = gid ? a1 : a0;
      sb  = gid ? b1 : b0;
      sop = gid ? op1 : op0;
      m_have  = 1'b1;
      m_id    = gid;
      m_last  = gid;
      m_a     = sa;
      m_b     = sb;
      m_op    = sop;
      m_err   = (sop == 2'b11);
      m_res   = m_err ? 32'h7FC0_0000 : fpu_fn(sa, sb, sop);
      m_avail = cyc + (m_err ? 1 : 2);
      acc0    = !gid;
      acc1    = gid;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Idle cycle used right after a reset edge to confirm every output is at its reset value.
  task automatic check_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_result", rsp_result, 32'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_fpu_b", fpu_b, 32'h0);
    check("rst_fpu_s", fpu_s, 2'b00);
    check("rst_op_count", op_count, '0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    logic x0, x1;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b1, x0, x1);
    end
  endtask

  task automatic new_payload(output logic [31:0] a, output logic [31:0] b, output logic [1:0] op);
    if ($urandom_range(0, 3) == 0) begin
      a = 32'h3FC0_0000;
      b = 32'h4010_0000;
    end else begin
      a = $urandom;
      b = $urandom;
    end
    op = 2'($urandom_range(0, 3));
  endtask

  // Random traffic: percent chances of a new request, rsp_ready high, and a reset cycle.
  task automatic run_traffic(input int n, input int p_req, input int p_rr, input int p_rst);
    logic acc0, acc1, rr, rn;
    for (int i = 0; i < n; i++) begin
      if (!pend0 && $urandom_range(0, 99) < p_req) begin
        pend0 = 1'b1;
        new_payload(ga0, gb0, gop0);
      end
      if (!pend1 && $urandom_range(0, 99) < p_req) begin
        pend1 = 1'b1;
        new_payload(ga1, gb1, gop1);
      end
      rr = ($urandom_range(0, 99) < p_rr);
      rn = !($urandom_range(0, 99) < p_rst);
      step(pend0, ga0, gb0, gop0, pend1, ga1, gb1, gop1, rr, rn, acc0, acc1);
      if (acc0) pend0 = 1'b0;
      if (acc1) pend1 = 1'b0;
    end
  endtask

  initial begin
    logic a0, a1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 32'h0; req0_b = 32'h0; req0_op = 2'b00;
    req1_a = 32'h0; req1_b = 32'h0; req1_op = 2'b00;
    pend0 = 1'b0; pend1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_reset();

    // Single add from requester 0.
    step(1'b1, 32'h3FC0_0000, 32'h4010_0000, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00,
         1'b1, 1'b1, a0, a1);
    check("add_accept", a0, 1'b1);
    idle_cycles(3);

    // Sub then mul from requester 1.
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h3FC0_0000, 32'h4010_0000, 2'b01,
         1'b1, 1'b1, a0, a1);
    check("sub_accept", a1, 1'b1);
    idle_cycles(3);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h3FC0_0000, 32'h4010_0000, 2'b10,
         1'b1, 1'b1, a0, a1);
    check("mul_accept", a1, 1'b1);
    idle_cycles(3);

    // Divide completes immediately with the error response.
    step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00,
         1'b1, 1'b1, a0, a1);
    check("div_accept", a0, 1'b1);
    idle_cycles(2);

    // Backpressure: response held while req1 waits, then req1 taken once IDLE returns.
    step(1'b1, 32'h3FC0_0000, 32'h4010_0000, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00,
         1'b0, 1'b1, a0, a1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0000_0007, 32'h0000_0003, 2'b10,
           1'b0, 1'b1, a0, a1);
      check("bp_stall", a1, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0000_0007, 32'h0000_0003, 2'b10,
         1'b1, 1'b1, a0, a1);
    check("bp_rsp_cycle_no_accept", a1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0000_0007, 32'h0000_0003, 2'b10,
         1'b1, 1'b1, a0, a1);
    check("bp_accept_after", a1, 1'b1);
    idle_cycles(3);

    // Contention right after reset: both requesters always valid.
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, a0, a1);
    check_reset();
    run_traffic(40, 100, 100, 0);

    // Reset while in EXEC abandons the operation.
    idle_cycles(4);
    pend0 = 1'b0; pend1 = 1'b0;
    step(1'b1, 32'h3FC0_0000, 32'h4010_0000, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00,
         1'b1, 1'b1, a0, a1);
    check("exec_rst_accept", a0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 1'b0, a0, a1);
    check_reset();
    idle_cycles(3);

    // Randomized mixed traffic with backpressure and occasional resets.
    run_traffic(800, 40, 70, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
